// File: rtl/if_fetch_stage.sv
// PC register, single-outstanding instruction fetch FSM and IF/ID pipeline register.
// Memory handshake: req/gnt address phase, then rvalid data phase; redirects discard stale responses.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] npc,
  input  logic        jump_taken,
  input  logic        id_stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, req_pc_q, hold_inst_q;
  logic        discard_q;

  logic        advance, req_pc_ld, discard_set, discard_clr, hold_ld, deliver;
  logic [31:0] deliver_inst;

  assign if_pc     = pc_q;
  assign inst_addr = pc_q;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (inst_gnt) state_d = S_WAIT;
      S_WAIT: if (inst_rvalid) state_d = (discard_q || jump_taken || !id_stall) ? S_REQ : S_HOLD;
      S_HOLD: if (jump_taken || !id_stall) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_req     = 1'b0;
    advance      = 1'b0;
    req_pc_ld    = 1'b0;
    discard_set  = 1'b0;
    discard_clr  = 1'b0;
    hold_ld      = 1'b0;
    deliver      = 1'b0;
    deliver_inst = inst_rdata;
    case (state_q)
      S_REQ: begin
        inst_req    = 1'b1;
        advance     = jump_taken;
        req_pc_ld   = inst_gnt & ~jump_taken;
        // Granted in the redirect cycle: the response is already stale.
        discard_set = inst_gnt & jump_taken;
      end
      S_WAIT: begin
        if (!inst_rvalid) begin
          discard_set = jump_taken;
          advance     = jump_taken;
        end else if (discard_q || jump_taken) begin
          discard_clr = 1'b1;
          advance     = jump_taken;
        end else if (!id_stall) begin
          deliver = 1'b1;
          advance = 1'b1;
        end else begin
          hold_ld = 1'b1;
        end
      end
      S_HOLD: begin
        deliver_inst = hold_inst_q;
        if (jump_taken) begin
          advance = 1'b1;
        end else if (!id_stall) begin
          deliver = 1'b1;
          advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      discard_q   <= 1'b0;
      hold_inst_q <= NOP_INST;
    end else begin
      if (advance)          pc_q        <= npc;
      if (req_pc_ld)        req_pc_q    <= pc_q;
      if (discard_set)      discard_q   <= 1'b1;
      else if (discard_clr) discard_q   <= 1'b0;
      if (hold_ld)          hold_inst_q <= inst_rdata;
    end
  end

  // Flush beats stall; without a delivery the register fills with a bubble.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_inst  <= NOP_INST;
    end else if (jump_taken) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (!id_stall) begin
      if (deliver) begin
        id_valid <= 1'b1;
        id_pc    <= req_pc_q;
        id_inst  <= deliver_inst;
      end else begin
        id_valid <= 1'b0;
        id_inst  <= NOP_INST;
      end
    end
  end

endmodule
